// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - FIFO read-side handshake between an async FIFO and the UART serializer
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_empty;
  logic [DATA_WIDTH-1:0] i_rd_data;
  logic                  o_rd_inc;

  // FIFO side: presents words and the empty flag, consumes the pop strobe
  modport master (
    output i_empty,
    output i_rd_data,
    input  o_rd_inc
  );

  // Serializer side: reads words and issues the pop strobe
  modport slave (
    input  i_empty,
    input  i_rd_data,
    output o_rd_inc
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame serializer fed from an async FIFO read port
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  uart_tx_serializer_if.slave  fifo,
  input  logic                 i_par_en,
  input  logic                 i_par_typ,
  input  logic [5:0]           i_prescale,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [5:0]            presc_q, presc_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  pop;

  // Bit-time counter reload: prescale 0 and 1 both mean a single cycle per bit
  function automatic logic [5:0] reload_of(input logic [5:0] p);
    return (p == 6'd0) ? 6'd0 : p - 6'd1;
  endfunction

  // A word may be popped only in IDLE or in the final cycle of the stop bit;
  // the strobe is qualified by the live empty flag and by reset so it can never
  // fire against an empty FIFO or while the block is held in reset
  always_comb begin
    pop = 1'b0;
    if (i_rstn && !fifo.i_empty) begin
      if (state_q == IDLE || (state_q == STOP && cnt_q == 6'd0)) begin
        pop = 1'b1;
      end
    end
  end

  assign fifo.o_rd_inc = pop;

  // Next-state and registered-output computation for the frame sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    presc_d   = presc_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    if (pop) begin
      data_d    = fifo.i_rd_data;
      par_en_d  = i_par_en;
      par_typ_d = i_par_typ;
      presc_d   = i_prescale;
      state_d   = START;
      cnt_d     = reload_of(i_prescale);
      idx_d     = '0;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
        START: begin
          if (cnt_q == 6'd0) begin
            state_d = DATA;
            idx_d   = '0;
            cnt_d   = reload_of(presc_q);
            tx_d    = data_q[0];
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        DATA: begin
          if (cnt_q == 6'd0) begin
            cnt_d = reload_of(presc_q);
            if (idx_q == LAST_IDX) begin
              if (par_en_q) begin
                state_d = PARITY;
                tx_d    = (^data_q) ^ par_typ_q;
              end else begin
                state_d = STOP;
                tx_d    = 1'b1;
              end
            end else begin
              idx_d = idx_q + 1'b1;
              tx_d  = data_q[idx_q + 1'b1];
            end
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        PARITY: begin
          if (cnt_q == 6'd0) begin
            state_d = STOP;
            cnt_d   = reload_of(presc_q);
            tx_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        STOP: begin
          if (cnt_q == 6'd0) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 6'd0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any frame and parks the line high
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= 6'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      presc_q   <= presc_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;

endmodule
